// File: rtl/rename_dispatch_nway_if.sv
// Bundle of rename/dispatch bus signals: instruction queue, free list, RAT,
// ROB/RS credits and the registered dispatch group.
interface rename_dispatch_nway_if #(
    parameter int PHYS_REG_BITS = 6,
    parameter int WIDTH         = 2,
    parameter int SLOT_BITS     = 5
);
    logic                           flush;
    logic [WIDTH-1:0]               iq_valid;
    logic [32*WIDTH-1:0]            iq_inst;
    logic [WIDTH-1:0]               iq_dequeue;
    logic [PHYS_REG_BITS:0]         fl_count;
    logic [PHYS_REG_BITS*WIDTH-1:0] fl_phys_reg;
    logic [WIDTH-1:0]               fl_dequeue;
    logic [5*WIDTH-1:0]             rat_rs1;
    logic [5*WIDTH-1:0]             rat_rs2;
    logic [PHYS_REG_BITS*WIDTH-1:0] rat_ps1;
    logic [PHYS_REG_BITS*WIDTH-1:0] rat_ps2;
    logic [WIDTH-1:0]               rat_ps1_valid;
    logic [WIDTH-1:0]               rat_ps2_valid;
    logic [WIDTH-1:0]               rat_we;
    logic [5*WIDTH-1:0]             rat_rd;
    logic [PHYS_REG_BITS*WIDTH-1:0] rat_pd;
    logic [SLOT_BITS:0]             rob_free;
    logic [SLOT_BITS:0]             rs_free;
    logic                           disp_ready;
    logic [WIDTH-1:0]               disp_valid;
    logic [32*WIDTH-1:0]            disp_inst;
    logic [PHYS_REG_BITS*WIDTH-1:0] disp_pd;
    logic [PHYS_REG_BITS*WIDTH-1:0] disp_ps1;
    logic [PHYS_REG_BITS*WIDTH-1:0] disp_ps2;
    logic [WIDTH-1:0]               disp_ps1_valid;
    logic [WIDTH-1:0]               disp_ps2_valid;

    // The environment (queue, free list, RAT, dispatch) side.
    modport master (
        output flush, iq_valid, iq_inst, fl_count, fl_phys_reg,
               rat_ps1, rat_ps2, rat_ps1_valid, rat_ps2_valid,
               rob_free, rs_free, disp_ready,
        input  iq_dequeue, fl_dequeue, rat_rs1, rat_rs2, rat_we, rat_rd, rat_pd,
               disp_valid, disp_inst, disp_pd, disp_ps1, disp_ps2,
               disp_ps1_valid, disp_ps2_valid
    );

    modport slave (
        input  flush, iq_valid, iq_inst, fl_count, fl_phys_reg,
               rat_ps1, rat_ps2, rat_ps1_valid, rat_ps2_valid,
               rob_free, rs_free, disp_ready,
        output iq_dequeue, fl_dequeue, rat_rs1, rat_rs2, rat_we, rat_rd, rat_pd,
               disp_valid, disp_inst, disp_pd, disp_ps1, disp_ps2,
               disp_ps1_valid, disp_ps2_valid
    );
endinterface

// File: rtl/rename_dispatch_nway.sv
// N-wide rename/dispatch: allocates free-list registers, renames sources with
// intra-group bypass, updates the RAT and registers the group for dispatch.
module rename_dispatch_nway #(
    parameter int PHYS_REG_BITS = 6,
    parameter int WIDTH         = 2,
    parameter int SLOT_BITS     = 5
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    rename_dispatch_nway_if.slave bus
);
    localparam int P = PHYS_REG_BITS;

    logic [WIDTH-1:0]    dispValid_q, dispValid_d;
    logic [32*WIDTH-1:0] dispInst_q;
    logic [P*WIDTH-1:0]  dispPd_q, dispPs1_q, dispPs2_q;
    logic [WIDTH-1:0]    dispPs1Valid_q, dispPs2Valid_q;

    logic [WIDTH-1:0]    accept, writesRd, ratWe, flDeq;
    logic [P*WIDTH-1:0]  pd_d, ps1_d, ps2_d;
    logic [WIDTH-1:0]    ps1Valid_d, ps2Valid_d;
    logic [P:0]          allocCnt;
    logic                stopped;
    logic [6:0]          opcode;
    logic [4:0]          rdA, rdB, rs1, rs2;

    // Walk lanes oldest-first; the first lane that fails any resource check
    // stops acceptance so the accepted lanes always form a prefix.
    always_comb begin
        accept   = '0;
        writesRd = '0;
        pd_d     = '0;
        allocCnt = '0;
        opcode   = '0;
        stopped  = !rst_ni || bus.flush || !((dispValid_q == '0) || bus.disp_ready);
        for (int i = 0; i < WIDTH; i++) begin
            opcode = bus.iq_inst[32*i +: 7];
            writesRd[i] = (opcode inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33})
                          && (bus.iq_inst[32*i+7 +: 5] != 5'd0);
            if (!stopped && bus.iq_valid[i]
                && ((allocCnt + (P+1)'(writesRd[i])) <= bus.fl_count)
                && ((SLOT_BITS+1)'(i + 1) <= bus.rob_free)
                && ((SLOT_BITS+1)'(i + 1) <= bus.rs_free)) begin
                accept[i] = 1'b1;
                if (writesRd[i]) begin
                    pd_d[P*i +: P] = bus.fl_phys_reg[P*int'(allocCnt) +: P];
                    allocCnt = allocCnt + (P+1)'(1);
                end
            end else begin
                stopped = 1'b1;
            end
        end
    end

    // Sources bypass from the youngest older writer in the group; an older
    // write to the same rd is dropped so the youngest mapping lands in the RAT.
    always_comb begin
        ps1_d      = bus.rat_ps1;
        ps2_d      = bus.rat_ps2;
        ps1Valid_d = bus.rat_ps1_valid;
        ps2Valid_d = bus.rat_ps2_valid;
        ratWe      = '0;
        flDeq      = '0;
        rdA        = '0;
        rdB        = '0;
        rs1        = '0;
        rs2        = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rdA = bus.iq_inst[32*i+7 +: 5];
            rs1 = bus.iq_inst[32*i+15 +: 5];
            rs2 = bus.iq_inst[32*i+20 +: 5];
            ratWe[i] = accept[i] && writesRd[i];
            for (int j = 0; j < WIDTH; j++) begin
                rdB = bus.iq_inst[32*j+7 +: 5];
                if (accept[j] && writesRd[j]) begin
                    if (j < i && rdB == rs1) begin
                        ps1_d[P*i +: P] = pd_d[P*j +: P];
                        ps1Valid_d[i]   = 1'b0;
                    end
                    if (j < i && rdB == rs2) begin
                        ps2_d[P*i +: P] = pd_d[P*j +: P];
                        ps2Valid_d[i]   = 1'b0;
                    end
                    if (j > i && rdB == rdA) begin
                        ratWe[i] = 1'b0;
                    end
                end
            end
            if (rs1 == 5'd0) begin
                ps1_d[P*i +: P] = '0;
                ps1Valid_d[i]   = 1'b1;
            end
            if (rs2 == 5'd0) begin
                ps2_d[P*i +: P] = '0;
                ps2Valid_d[i]   = 1'b1;
            end
            flDeq[i] = (P+1)'(i) < allocCnt;
        end
    end

    always_comb begin
        if (bus.flush) begin
            dispValid_d = '0;
        end else if (accept[0]) begin
            dispValid_d = accept;
        end else if (bus.disp_ready) begin
            dispValid_d = '0;
        end else begin
            dispValid_d = dispValid_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dispValid_q    <= '0;
            dispInst_q     <= '0;
            dispPd_q       <= '0;
            dispPs1_q      <= '0;
            dispPs2_q      <= '0;
            dispPs1Valid_q <= '0;
            dispPs2Valid_q <= '0;
        end else begin
            dispValid_q <= dispValid_d;
            if (accept[0]) begin
                dispInst_q     <= bus.iq_inst;
                dispPd_q       <= pd_d;
                dispPs1_q      <= ps1_d;
                dispPs2_q      <= ps2_d;
                dispPs1Valid_q <= ps1Valid_d;
                dispPs2Valid_q <= ps2Valid_d;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : gLaneAddr
        assign bus.rat_rs1[5*g +: 5] = bus.iq_inst[32*g+15 +: 5];
        assign bus.rat_rs2[5*g +: 5] = bus.iq_inst[32*g+20 +: 5];
        assign bus.rat_rd[5*g +: 5]  = bus.iq_inst[32*g+7 +: 5];
    end

    assign bus.iq_dequeue     = accept;
    assign bus.fl_dequeue     = flDeq;
    assign bus.rat_we         = ratWe;
    assign bus.rat_pd         = pd_d;
    assign bus.disp_valid     = dispValid_q;
    assign bus.disp_inst      = dispInst_q;
    assign bus.disp_pd        = dispPd_q;
    assign bus.disp_ps1       = dispPs1_q;
    assign bus.disp_ps2       = dispPs2_q;
    assign bus.disp_ps1_valid = dispPs1Valid_q;
    assign bus.disp_ps2_valid = dispPs2Valid_q;
endmodule

// File: tb/tb_rename_dispatch_nway.sv
// Bench for rename_dispatch_nway: directed scenarios plus random groups checked
// against a behavioural rename model with its own RAT and output register.
module tb_rename_dispatch_nway;
    localparam int P = 6;
    localparam int W = 2;
    localparam int S = 5;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    rename_dispatch_nway_if #(.PHYS_REG_BITS(P), .WIDTH(W), .SLOT_BITS(S)) bus ();

    rename_dispatch_nway #(.PHYS_REG_BITS(P), .WIDTH(W), .SLOT_BITS(S)) dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Stimulus
    int          nValid;
    logic [31:0] sInst[W];
    logic [P:0]  sFlCount;
    logic [P-1:0] sFl[W];
    logic [S:0]  sRob, sRs;
    logic        sReady, sFlush;

    // Architectural map model, driven back to the DUT as the RAT
    logic [P-1:0] ratMap[32];
    logic         ratRdy[32];

    // Expected combinational results
    int           expK, expAlloc;
    logic [P-1:0] mPd[W], mPs1[W], mPs2[W];
    logic         mV1[W], mV2[W];
    logic [W-1:0] mRatWe;

    // Expected output register
    logic [W-1:0] rValid;
    logic [31:0]  rInst[W];
    logic [P-1:0] rPd[W], rPs1[W], rPs2[W];
    logic         rV1[W], rV2[W];

    logic [6:0] ops[9];

    always_comb begin
        bus.rat_ps1       = '0;
        bus.rat_ps2       = '0;
        bus.rat_ps1_valid = '0;
        bus.rat_ps2_valid = '0;
        for (int l = 0; l < W; l++) begin
            bus.rat_ps1[P*l +: P]   = ratMap[bus.rat_rs1[5*l +: 5]];
            bus.rat_ps2[P*l +: P]   = ratMap[bus.rat_rs2[5*l +: 5]];
            bus.rat_ps1_valid[l]    = ratRdy[bus.rat_rs1[5*l +: 5]];
            bus.rat_ps2_valid[l]    = ratRdy[bus.rat_rs2[5*l +: 5]];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic isWriter(input logic [31:0] inst);
        case (inst[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33: return inst[11:7] != 5'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] thermo(input int n);
        logic [W-1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) if (i < n) t[i] = 1'b1;
        return t;
    endfunction

    task automatic lookupSrc(input int lane, input logic [4:0] r,
                             output logic [P-1:0] p, output logic v);
        p = ratMap[r];
        v = ratRdy[r];
        if (r == 5'd0) begin
            p = '0;
            v = 1'b1;
            return;
        end
        for (int j = lane - 1; j >= 0; j--) begin
            if (j < expK && isWriter(sInst[j]) && sInst[j][11:7] == r) begin
                p = mPd[j];
                v = 1'b0;
                return;
            end
        end
    endtask

    task automatic applyStimulus();
        bus.iq_valid   = thermo(nValid);
        bus.fl_count   = sFlCount;
        bus.rob_free   = sRob;
        bus.rs_free    = sRs;
        bus.disp_ready = sReady;
        bus.flush      = sFlush;
        for (int i = 0; i < W; i++) begin
            bus.iq_inst[32*i +: 32]  = sInst[i];
            bus.fl_phys_reg[P*i +: P] = sFl[i];
        end
    endtask

    // Accept count is the largest prefix length for which every resource limit holds.
    task automatic modelComb();
        int  need[W+1];
        logic slot;
        need[0] = 0;
        for (int c = 0; c < W; c++) need[c+1] = need[c] + (isWriter(sInst[c]) ? 1 : 0);
        slot = (rValid == '0) || sReady;
        expK = 0;
        for (int c = W; c >= 1; c--) begin
            if (expK == 0 && c <= nValid && need[c] <= int'(sFlCount) && c <= int'(sRob)
                && c <= int'(sRs) && slot && !sFlush && rstN)
                expK = c;
        end
        expAlloc = need[expK];
        for (int i = 0; i < W; i++)
            mPd[i] = (i < expK && isWriter(sInst[i])) ? sFl[need[i]] : '0;
        for (int i = 0; i < W; i++) begin
            lookupSrc(i, sInst[i][19:15], mPs1[i], mV1[i]);
            lookupSrc(i, sInst[i][24:20], mPs2[i], mV2[i]);
            mRatWe[i] = (i < expK) && isWriter(sInst[i]);
            for (int j = i + 1; j < expK; j++)
                if (isWriter(sInst[j]) && sInst[j][11:7] == sInst[i][11:7]) mRatWe[i] = 1'b0;
        end
    endtask

    task automatic driveAndCheckComb();
        applyStimulus();
        #2;
        modelComb();
        checkOutput("iq_dequeue", 64'(bus.iq_dequeue), 64'(thermo(expK)));
        checkOutput("fl_dequeue", 64'(bus.fl_dequeue), 64'(thermo(expAlloc)));
        checkOutput("rat_we", 64'(bus.rat_we), 64'(mRatWe));
        for (int i = 0; i < W; i++) begin
            if (mRatWe[i]) begin
                checkOutput("rat_pd", 64'(bus.rat_pd[P*i +: P]), 64'(mPd[i]));
                checkOutput("rat_rd", 64'(bus.rat_rd[5*i +: 5]), 64'(sInst[i][11:7]));
            end
        end
    endtask

    task automatic clockAndCheckReg();
        @(posedge clk);
        #1;
        if (sFlush) begin
            rValid = '0;
        end else if (expK > 0) begin
            rValid = thermo(expK);
            for (int i = 0; i < W; i++) begin
                rInst[i] = sInst[i]; rPd[i] = mPd[i];
                rPs1[i] = mPs1[i]; rPs2[i] = mPs2[i];
                rV1[i] = mV1[i]; rV2[i] = mV2[i];
            end
        end else if (sReady) begin
            rValid = '0;
        end
        for (int i = 0; i < W; i++) begin
            if (mRatWe[i]) begin
                ratMap[sInst[i][11:7]] = mPd[i];
                ratRdy[sInst[i][11:7]] = 1'b0;
            end
        end
        checkOutput("disp_valid", 64'(bus.disp_valid), 64'(rValid));
        for (int i = 0; i < W; i++) begin
            if (rValid[i]) begin
                checkOutput("disp_inst", 64'(bus.disp_inst[32*i +: 32]), 64'(rInst[i]));
                checkOutput("disp_pd", 64'(bus.disp_pd[P*i +: P]), 64'(rPd[i]));
                checkOutput("disp_ps1", 64'(bus.disp_ps1[P*i +: P]), 64'(rPs1[i]));
                checkOutput("disp_ps2", 64'(bus.disp_ps2[P*i +: P]), 64'(rPs2[i]));
                checkOutput("disp_ps1_valid", 64'(bus.disp_ps1_valid[i]), 64'(rV1[i]));
                checkOutput("disp_ps2_valid", 64'(bus.disp_ps2_valid[i]), 64'(rV2[i]));
            end
        end
        @(negedge clk);
    endtask

    task automatic setPair(input logic [31:0] a, input logic [31:0] b);
        sInst[0] = a;
        sInst[1] = b;
        nValid   = 2;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33, 7'h23, 7'h63};
        for (int r = 0; r < 32; r++) begin
            ratMap[r] = P'(r);
            ratRdy[r] = 1'b1;
        end
        rValid = '0;
        for (int i = 0; i < W; i++) begin
            sInst[i] = 32'h0000_0013; sFl[i] = '0;
            rInst[i] = '0; rPd[i] = '0; rPs1[i] = '0; rPs2[i] = '0; rV1[i] = 1'b0; rV2[i] = 1'b0;
        end
        nValid = 0; sFlCount = '0; sRob = 7'd8; sRs = 7'd8; sReady = 1'b1; sFlush = 1'b0;
        rstN = 1'b0;
        applyStimulus();
        #12;
        checkOutput("reset_disp_valid", 64'(bus.disp_valid), 64'd0);
        checkOutput("reset_disp_pd", 64'(bus.disp_pd), 64'd0);
        checkOutput("reset_iq_dequeue", 64'(bus.iq_dequeue), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Dependent pair: lane1 reads lane0's fresh destination
        setPair(32'h00C401B3, 32'h00318233);
        sFl[0] = 6'd40; sFl[1] = 6'd41; sFlCount = 7'd8;
        driveAndCheckComb();
        checkOutput("dep_fl_dequeue", 64'(bus.fl_dequeue), 64'h3);
        checkOutput("dep_rat_we", 64'(bus.rat_we), 64'h3);
        clockAndCheckReg();
        checkOutput("dep_pd0", 64'(bus.disp_pd[0 +: P]), 64'd40);
        checkOutput("dep_pd1", 64'(bus.disp_pd[P +: P]), 64'd41);
        checkOutput("dep_ps0", 64'({bus.disp_ps1[0 +: P], bus.disp_ps2[0 +: P]}), 64'({6'd8, 6'd12}));
        checkOutput("dep_ps1", 64'({bus.disp_ps1[P +: P], bus.disp_ps2[P +: P]}), 64'({6'd40, 6'd40}));
        checkOutput("dep_psv", 64'({bus.disp_ps1_valid, bus.disp_ps2_valid}), 64'(4'b0101));

        // Free-list shortfall: only one destination available
        sFl[0] = 6'd42; sFl[1] = 6'd43; sFlCount = 7'd1;
        driveAndCheckComb();
        checkOutput("short_iq_dequeue", 64'(bus.iq_dequeue), 64'h1);
        checkOutput("short_fl_dequeue", 64'(bus.fl_dequeue), 64'h1);
        clockAndCheckReg();
        checkOutput("short_disp_valid", 64'(bus.disp_valid), 64'h1);

        // Non-writers need no destination
        setPair(32'h00532023, 32'h00000013);
        sFlCount = 7'd0;
        driveAndCheckComb();
        checkOutput("nw_fl_dequeue", 64'(bus.fl_dequeue), 64'h0);
        checkOutput("nw_rat_we", 64'(bus.rat_we), 64'h0);
        clockAndCheckReg();
        checkOutput("nw_disp_pd", 64'(bus.disp_pd), 64'h0);
        checkOutput("nw_disp_valid", 64'(bus.disp_valid), 64'h3);

        // Resource stalls
        setPair(32'h00C401B3, 32'h00318233);
        sFlCount = 7'd8; sRob = 7'd0;
        driveAndCheckComb();
        checkOutput("rob_iq_dequeue", 64'(bus.iq_dequeue), 64'h0);
        clockAndCheckReg();
        sRob = 7'd8; sRs = 7'd1;
        driveAndCheckComb();
        checkOutput("rs_iq_dequeue", 64'(bus.iq_dequeue), 64'h1);
        clockAndCheckReg();
        sRs = 7'd8;

        // Backpressure: group holds while downstream is not ready
        driveAndCheckComb();
        clockAndCheckReg();
        sReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            driveAndCheckComb();
            checkOutput("bp_iq_dequeue", 64'(bus.iq_dequeue), 64'h0);
            clockAndCheckReg();
        end
        sFlush = 1'b1;
        driveAndCheckComb();
        checkOutput("flush_iq_dequeue", 64'(bus.iq_dequeue), 64'h0);
        clockAndCheckReg();
        checkOutput("flush_disp_valid", 64'(bus.disp_valid), 64'h0);
        sFlush = 1'b0; sReady = 1'b1;

        // Reset while a full group is held
        driveAndCheckComb();
        clockAndCheckReg();
        checkOutput("pre_rst_disp_valid", 64'(bus.disp_valid), 64'h3);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("rst_disp_valid", 64'(bus.disp_valid), 64'h0);
        checkOutput("rst_iq_dequeue", 64'(bus.iq_dequeue), 64'h0);
        checkOutput("rst_fl_dequeue", 64'(bus.fl_dequeue), 64'h0);
        checkOutput("rst_rat_we", 64'(bus.rat_we), 64'h0);
        rValid = '0;
        @(negedge clk);
        rstN = 1'b1;
        driveAndCheckComb();
        clockAndCheckReg();
        checkOutput("post_rst_disp_valid", 64'(bus.disp_valid), 64'h3);

        // Random groups against the reference model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < W; i++) begin
                sInst[i] = {7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'd0,
                            5'($urandom_range(0, 7)), ops[$urandom_range(0, 8)]};
                sFl[i] = P'($urandom_range(1, 63));
            end
            nValid   = $urandom_range(0, W);
            sFlCount = 7'($urandom_range(0, 3));
            sRob     = ($urandom_range(0, 9) < 2) ? 7'($urandom_range(0, 1)) : 7'd8;
            sRs      = ($urandom_range(0, 9) < 2) ? 7'($urandom_range(0, 1)) : 7'd8;
            sReady   = 1'($urandom_range(0, 1));
            sFlush   = ($urandom_range(0, 9) == 0);
            ratRdy[$urandom_range(1, 31)] = 1'b1;
            driveAndCheckComb();
            clockAndCheckReg();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/rename_dispatch_nway.md
Name: rename_dispatch_nway

Overview:
Parametrised N-wide successor to the single-lane rename/dispatch stage. Each cycle it takes up to WIDTH in-order instructions from the instruction queue, allocates physical destinations from the free list, and reads source mappings from the RAT, correcting them for dependencies inside the group. It writes new mappings to the RAT and holds the renamed group in a registered output stage with a valid/ready handshake toward ROB/RS dispatch. It adds partial-group acceptance, flush, and backpressure, which the single-lane stage lacks.

Parameters:
PHYS_REG_BITS, 6, physical register index width (P)
WIDTH, 2, lanes renamed per cycle (1..4)
SLOT_BITS, 5, width of ROB/RS free-slot counts (count ports are SLOT_BITS+1 wide)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flush  in  1  pipeline flush; drops the output group and blocks acceptance this cycle
iq_valid  in  WIDTH  lane valid; valid lanes are contiguous from lane 0
iq_inst  in  32*WIDTH  lane instructions; lane 0 is oldest
iq_dequeue  out  WIDTH  lane consumed this cycle
fl_count  in  P+1  free-list entries available
fl_phys_reg  in  P*WIDTH  next WIDTH free registers, head first
fl_dequeue  out  WIDTH  thermometer count of pops this cycle
rat_rs1, rat_rs2  out  5*WIDTH  RAT read addresses
rat_ps1, rat_ps2  in  P*WIDTH  RAT read data
rat_ps1_valid, rat_ps2_valid  in  WIDTH  RAT ready bits
rat_we  out  WIDTH  RAT write enable per lane
rat_rd  out  5*WIDTH  RAT write architectural register
rat_pd  out  P*WIDTH  RAT write physical register
rob_free, rs_free  in  SLOT_BITS+1  free ROB / RS entries
disp_ready  in  1  downstream accepts the output group
disp_valid  out  WIDTH  registered lane valid
disp_inst  out  32*WIDTH  registered instruction
disp_pd, disp_ps1, disp_ps2  out  P*WIDTH  registered physical registers
disp_ps1_valid, disp_ps2_valid  out  WIDTH  registered source-ready bits

Behaviour:
- Writes rd: opcodes LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP with rd!=0. Store, branch, and rd==x0 lanes need no pd; they get pd=0 and rat_we=0.
- Slot available: output register is empty, or disp_ready=1.
- Accept count k: the largest prefix 0..k-1 of valid lanes such that all of the following hold. Lanes needing pd count ≤ fl_count; k ≤ rob_free; k ≤ rs_free; a slot is available; flush=0.
- No lane beyond the first rejected lane is accepted, so order is preserved.
- Lane i takes fl_phys_reg slot n, where n is the number of accepted lanes before i that need pd. fl_dequeue has its low m bits set, where m is the total number of pd allocations.
- iq_dequeue[i] = 1 for i<k. rat_we is asserted only for accepted lanes that write rd. All of these are combinational in the same cycle.
- Source rs==x0: ps=0, ps_valid=1.
- Source rs matches the rd of an earlier accepted writing lane in the group: ps is that lane's pd and ps_valid=0. The youngest earlier match wins. Otherwise ps and ps_valid come from the RAT.
- Lanes writing the same rd in one group: RAT write priority goes to the highest lane index.
- Output register, on a clk edge:
  - flush=1: disp_valid is cleared.
  - else if k>0: the register loads the group; disp_valid = low k bits set.
  - else if disp_ready=1: disp_valid is cleared.
  - else: the register holds.
- Reset (rst=0, asynchronous): all disp_* outputs are 0. iq_dequeue, fl_dequeue, and rat_we are 0 while in reset.
- Latency: 1 cycle from acceptance to disp_valid.

Test Plan:
- Dependent pair. Lane0 0x00C401B3 (add x3,x8,x12), lane1 0x00318233 (add x4,x3,x3), fl regs 40,41, fl_count=8, RAT x8→8/valid, x12→12/valid. Required same cycle: fl_dequeue=11, rat_we=11. Required next cycle: disp_pd=40,41; lane0 ps1=8, ps2=12, valid=1; lane1 ps1=ps2=40, valid=0.
- Free-list shortfall. Same pair with fl_count=1 -> k=1: iq_dequeue=01, fl_dequeue=01, disp_valid=01 next cycle.
- Non-writers. Lane0 0x00532023 (sw x5,0(x6)), lane1 0x00000013 (addi x0,x0,0), fl_count=0 -> both accepted: fl_dequeue=00, rat_we=00, disp_pd=0,0.
- Resource stall. rob_free=0 (or rs_free=1 with 2 valid lanes) -> k=0 (or 1): no dequeues beyond k, disp_valid updates accordingly.
- Backpressure and flush. Group held with disp_ready=0 for 3 cycles -> outputs stable, iq_dequeue=00. Assert flush -> disp_valid=00 next edge, no dequeues that cycle.
- Reset mid-operation. Drop rst while disp_valid=11 -> disp_valid=00 immediately, without waiting for a clock edge. The first group after reset renames normally.
